// File: rtl/sseg_bcd_capture_if.sv
// Frame output port of the seven-segment capture block:
// BCD frame, error flag and valid/ready handshake.
interface sseg_bcd_capture_if #(
  parameter int N_DIGITS = 4
) ();
  logic [4*N_DIGITS-1:0] frame_out;
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  frame_err;

  modport master (
    output frame_out,
    output frame_valid,
    output frame_err,
    input  frame_ready
  );

  modport slave (
    input  frame_out,
    input  frame_valid,
    input  frame_err,
    output frame_ready
  );
endinterface

// File: rtl/sseg_bcd_capture.sv
// Samples a multiplexed seven-segment bus, decodes stable digits
// back to BCD and emits one frame of N_DIGITS nibbles per round.
module sseg_bcd_capture #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  input  logic [N_DIGITS-1:0] dig_sel_in,
  sseg_bcd_capture_if.master  frm,
  output logic                overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = N_DIGITS + 7;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);

  logic [SW-1:0]         smp_q, smp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cap_q, cap_d;
  logic [4*N_DIGITS-1:0] slot_q, slot_d;
  logic [N_DIGITS-1:0]   err_q, err_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic [4*N_DIGITS-1:0] out_q, out_d;
  logic                  vld_q, vld_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  logic                  qual;
  logic                  same;
  logic                  fire;
  logic                  complete;
  logic                  xfer;
  logic                  load;
  logic [4:0]            dec;
  logic [N_DIGITS-1:0]   smp_sel;

  // bit4 = pattern recognised, bits3:0 = nibble (F when unknown)
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = 5'h10;
      7'b0110000: r = 5'h11;
      7'b1101101: r = 5'h12;
      7'b1111001: r = 5'h13;
      7'b0110011: r = 5'h14;
      7'b1011011: r = 5'h15;
      7'b1011111: r = 5'h16;
      7'b1110000: r = 5'h17;
      7'b1111111: r = 5'h18;
      7'b1111011: r = 5'h19;
      default:    r = 5'h0F;
    endcase
    return r;
  endfunction

  assign smp_sel = smp_q[SW-1:7];
  assign dec     = decode(smp_q[6:0]);

  always_comb begin
    qual = (dig_sel_in != '0) &&
           ((dig_sel_in & (dig_sel_in - 1'b1)) == '0);
    same = ({dig_sel_in, seg_in} == smp_q);
    smp_d = {dig_sel_in, seg_in};

    cnt_d = cnt_q;
    if (!qual)
      cnt_d = '0;
    else if (same)
      cnt_d = (cnt_q == CMAX) ? CMAX : cnt_q + 1'b1;
    else
      cnt_d = CW'(1);

    // one capture per dwell: flag holds until the sample changes
    fire  = (cnt_q == CMAX) && !cap_q;
    cap_d = (!qual || !same) ? 1'b0 : (cap_q | fire);

    complete = &seen_q;
    xfer     = vld_q & frm.frame_ready;
    load     = complete & (!vld_q | xfer);

    slot_d = slot_q;
    seen_d = complete ? '0 : seen_q;
    err_d  = complete ? '0 : err_q;
    if (fire) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (smp_sel[i]) begin
          slot_d[4*i +: 4] = dec[3:0];
          seen_d[i]        = 1'b1;
          err_d[i]         = ~dec[4];
        end
      end
    end

    out_d  = out_q;
    ferr_d = ferr_q;
    vld_d  = xfer ? 1'b0 : vld_q;
    if (load) begin
      out_d  = slot_q;
      ferr_d = |err_q;
      vld_d  = 1'b1;
    end
    ovr_d = complete & vld_q & ~frm.frame_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_q  <= '0;
      cnt_q  <= '0;
      cap_q  <= 1'b0;
      slot_q <= '0;
      err_q  <= '0;
      seen_q <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      smp_q  <= smp_d;
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
      slot_q <= slot_d;
      err_q  <= err_d;
      seen_q <= seen_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign frm.frame_out   = out_q;
  assign frm.frame_valid = vld_q;
  assign frm.frame_err   = ferr_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_sseg_bcd_capture.sv
// Directed bench for sseg_bcd_capture (N_DIGITS=4,
// STABLE_CYCLES=4) with hand-computed frames.
module tb_sseg_bcd_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] sel;
  logic       ovr;
  int         tests = 0;
  int         fails = 0;

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;

  sseg_bcd_capture_if #(.N_DIGITS(4)) bus ();

  sseg_bcd_capture #(
    .N_DIGITS(4),
    .STABLE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg),
    .dig_sel_in(sel),
    .frm(bus),
    .overrun(ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input int d, input logic [6:0] s, input int n);
    sel = 4'(1 << d);
    seg = s;
    repeat (n) tick();
  endtask

  task automatic blank(input int n);
    sel = 4'b0000;
    seg = 7'b0000000;
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    sel = '0;
    seg = '0;
    bus.frame_ready = 1'b1;
    tick();
    tick();
    chk("rst_out", {16'h0, bus.frame_out}, 32'h0);
    chk("rst_valid", {31'h0, bus.frame_valid}, 32'h0);
    chk("rst_err", {31'h0, bus.frame_err}, 32'h0);
    chk("rst_ovr", {31'h0, ovr}, 32'h0);
    rst_n = 1'b1;

    // basic frame, first valid at edge S+2 of digit 3 dwell
    dwell(0, P0, 8);
    dwell(1, P1, 8);
    dwell(2, P2, 8);
    dwell(3, P3, 5);
    chk("t1_valid_e5", {31'h0, bus.frame_valid}, 32'h0);
    tick();
    chk("t1_valid_e6", {31'h0, bus.frame_valid}, 32'h1);
    chk("t1_out", {16'h0, bus.frame_out}, 32'h3210);
    chk("t1_err", {31'h0, bus.frame_err}, 32'h0);
    tick();
    chk("t1_valid_e7", {31'h0, bus.frame_valid}, 32'h0);
    tick();

    // short dwell on digit 2 is not captured
    dwell(0, P5, 6);
    dwell(1, P6, 6);
    dwell(2, P7, 3);
    dwell(3, P8, 6);
    blank(2);
    chk("t2_noframe", {31'h0, bus.frame_valid}, 32'h0);
    dwell(2, P7, 4);
    blank(1);
    chk("t2_valid_cap", {31'h0, bus.frame_valid}, 32'h0);
    tick();
    chk("t2_valid", {31'h0, bus.frame_valid}, 32'h1);
    chk("t2_out", {16'h0, bus.frame_out}, 32'h8765);
    tick();
    chk("t2_drop", {31'h0, bus.frame_valid}, 32'h0);

    // undecodable digit
    dwell(0, P0, 5);
    dwell(1, 7'b1000000, 5);
    dwell(2, P2, 5);
    dwell(3, P3, 4);
    blank(2);
    chk("t3_valid", {31'h0, bus.frame_valid}, 32'h1);
    chk("t3_out", {16'h0, bus.frame_out}, 32'h32F0);
    chk("t3_err", {31'h0, bus.frame_err}, 32'h1);
    tick();
    dwell(0, P9, 5);
    dwell(1, P1, 5);
    dwell(2, P4, 5);
    dwell(3, P3, 4);
    blank(2);
    chk("t3b_valid", {31'h0, bus.frame_valid}, 32'h1);
    chk("t3b_out", {16'h0, bus.frame_out}, 32'h3419);
    chk("t3b_err", {31'h0, bus.frame_err}, 32'h0);
    tick();

    // backpressure and overrun
    bus.frame_ready = 1'b0;
    dwell(0, P1, 5);
    dwell(1, P2, 5);
    dwell(2, P3, 5);
    dwell(3, P4, 4);
    blank(2);
    chk("t4_valid", {31'h0, bus.frame_valid}, 32'h1);
    chk("t4_out", {16'h0, bus.frame_out}, 32'h4321);
    dwell(0, P5, 5);
    dwell(1, P6, 5);
    dwell(2, P7, 5);
    dwell(3, P8, 4);
    blank(1);
    chk("t4_ovr_pre", {31'h0, ovr}, 32'h0);
    tick();
    chk("t4_ovr", {31'h0, ovr}, 32'h1);
    chk("t4_hold", {16'h0, bus.frame_out}, 32'h4321);
    chk("t4_hold_v", {31'h0, bus.frame_valid}, 32'h1);
    tick();
    chk("t4_ovr_post", {31'h0, ovr}, 32'h0);
    chk("t4_hold2", {16'h0, bus.frame_out}, 32'h4321);
    bus.frame_ready = 1'b1;
    tick();
    chk("t4_xfer", {31'h0, bus.frame_valid}, 32'h0);

    // load on the same edge as a transfer
    bus.frame_ready = 1'b0;
    dwell(0, P9, 5);
    dwell(1, P9, 5);
    dwell(2, P9, 5);
    dwell(3, P9, 4);
    blank(2);
    chk("t4b_out1", {16'h0, bus.frame_out}, 32'h9999);
    dwell(0, P0, 5);
    dwell(1, P0, 5);
    dwell(2, P0, 5);
    dwell(3, P0, 4);
    blank(1);
    bus.frame_ready = 1'b1;
    tick();
    chk("t4b_valid", {31'h0, bus.frame_valid}, 32'h1);
    chk("t4b_out2", {16'h0, bus.frame_out}, 32'h0000);
    chk("t4b_ovr", {31'h0, ovr}, 32'h0);
    tick();
    chk("t4b_drop", {31'h0, bus.frame_valid}, 32'h0);

    // blanking and 2-hot interrupt the dwell
    dwell(0, P7, 3);
    blank(1);
    dwell(0, P7, 3);
    sel = 4'b0011;
    tick();
    dwell(0, P7, 3);
    dwell(1, P1, 5);
    dwell(2, P2, 5);
    dwell(3, P3, 5);
    blank(2);
    chk("t5_noframe", {31'h0, bus.frame_valid}, 32'h0);
    dwell(0, P6, 4);
    blank(2);
    chk("t5_valid", {31'h0, bus.frame_valid}, 32'h1);
    chk("t5_out", {16'h0, bus.frame_out}, 32'h3216);
    tick();

    // reset mid-frame discards partial state
    dwell(0, P8, 5);
    dwell(1, P8, 5);
    dwell(2, P8, 5);
    blank(0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_out", {16'h0, bus.frame_out}, 32'h0);
    chk("t6_valid", {31'h0, bus.frame_valid}, 32'h0);
    chk("t6_err", {31'h0, bus.frame_err}, 32'h0);
    chk("t6_ovr", {31'h0, ovr}, 32'h0);
    dwell(3, P5, 5);
    blank(2);
    chk("t6_noframe", {31'h0, bus.frame_valid}, 32'h0);
    dwell(0, P1, 5);
    dwell(1, P1, 5);
    dwell(2, P1, 4);
    blank(2);
    chk("t6_valid2", {31'h0, bus.frame_valid}, 32'h1);
    chk("t6_out2", {16'h0, bus.frame_out}, 32'h5111);
    chk("t6_err2", {31'h0, bus.frame_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
